// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes host bitstream words MSB-first onto the configuration flip-flop chain, with optional read-back verify
module ccff_chain_loader #(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 1024,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              verify_err
);

    localparam int WB_W = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT
    } state_t;

    state_t            state_q;
    logic              mode_q;
    logic [WORD_W-1:0] sreg_q;
    logic [WB_W-1:0]   word_bits_q;
    logic [CNT_W-1:0]  bits_left_q;
    logic              done_q;
    logic              verify_err_q;

    logic [WB_W-1:0]   word_bits_d;
    logic              mismatch_d;

    // Bits to take from the next word: a full word, or only what remains of the chain
    always_comb begin
        word_bits_d = WB_W'(WORD_W);
        if (32'(bits_left_q) < WORD_W) begin
            word_bits_d = WB_W'(bits_left_q);
        end
    end

    // Read-back compare: after a full load pass the tail presents the bit now at the head
    always_comb begin
        mismatch_d = 1'b0;
        if (state_q == S_SHIFT && mode_q && (ccff_tail != sreg_q[WORD_W-1])) begin
            mismatch_d = 1'b1;
        end
    end

    // Pass sequencer: IDLE waits for start, LOAD takes one word, SHIFT drains it onto the chain
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state_q      <= S_IDLE;
            mode_q       <= 1'b0;
            sreg_q       <= '0;
            word_bits_q  <= '0;
            bits_left_q  <= '0;
            done_q       <= 1'b0;
            verify_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        mode_q       <= verify;
                        done_q       <= 1'b0;
                        verify_err_q <= 1'b0;
                        bits_left_q  <= CNT_W'(CHAIN_LEN);
                        state_q      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (word_valid) begin
                        sreg_q      <= word_in;
                        word_bits_q <= word_bits_d;
                        state_q     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sreg_q      <= sreg_q << 1;
                    word_bits_q <= word_bits_q - 1'b1;
                    bits_left_q <= bits_left_q - 1'b1;
                    if (mismatch_d) begin
                        verify_err_q <= 1'b1;
                    end
                    if (word_bits_q == WB_W'(1)) begin
                        if (bits_left_q == CNT_W'(1)) begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs come from registered state only; word_in never reaches the chain combinationally
    assign word_ready    = (state_q == S_LOAD);
    assign ccff_shift_en = (state_q == S_SHIFT);
    assign ccff_head     = (state_q == S_SHIFT) ? sreg_q[WORD_W-1] : 1'b0;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign verify_err    = verify_err_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed vector bench for ccff_chain_loader (16-bit and 12-bit chains)
module tb_ccff_chain_loader;

    typedef struct {
        bit          sel_b;
        bit          vfy;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [15:0] exp_bits;
        int          exp_len;
        bit          exp_pre;
        bit          exp_err;
        int          stall_max;
        bit          poke;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic       verify = 1'b0;
    logic [7:0] word_in = 8'h00;
    logic       word_valid = 1'b0;

    logic ready_a, head_a, shift_a, busy_a, done_a, err_a, tail_a;
    logic ready_b, head_b, shift_b, busy_b, done_b, err_b;
    logic o_ready, o_head, o_shift, o_busy, o_done, o_err;
    logic sel_b = 1'b0;

    logic [15:0] chain16 = 16'h0000;

    int total = 0;
    int bad = 0;
    vec_t vecs[9];

    always #5 clk = ~clk;

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(16)) dut_a (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start_a), .verify(verify),
        .word_in(word_in), .word_valid(word_valid), .word_ready(ready_a),
        .ccff_head(head_a), .ccff_shift_en(shift_a), .ccff_tail(tail_a),
        .busy(busy_a), .done(done_a), .verify_err(err_a)
    );

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(12)) dut_b (
        .prog_clk(clk), .prog_reset_n(rst_n), .start(start_b), .verify(verify),
        .word_in(word_in), .word_valid(word_valid), .word_ready(ready_b),
        .ccff_head(head_b), .ccff_shift_en(shift_b), .ccff_tail(1'b0),
        .busy(busy_b), .done(done_b), .verify_err(err_b)
    );

    // 16-flop chain model hung off dut_a
    always @(posedge clk) begin
        if (shift_a) chain16 <= {chain16[14:0], head_a};
    end
    assign tail_a = chain16[15];

    assign o_ready = sel_b ? ready_b : ready_a;
    assign o_head  = sel_b ? head_b  : head_a;
    assign o_shift = sel_b ? shift_b : shift_a;
    assign o_busy  = sel_b ? busy_b  : busy_a;
    assign o_done  = sel_b ? done_b  : done_a;
    assign o_err   = sel_b ? err_b   : err_a;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic run_pass(input int n, input vec_t v);
        logic [7:0]  words[2];
        logic [15:0] cap = 16'h0000;
        int widx = 0;
        int nshift = 0;
        int ncyc = 0;
        int stall = 0;
        bit seen_done = 1'b0;
        bit err_last = 1'b0;
        words[0] = v.w0;
        words[1] = v.w1;
        sel_b = v.sel_b;
        @(negedge clk);
        start_a = !v.sel_b;
        start_b = v.sel_b;
        verify  = v.vfy;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        verify  = !v.vfy;
        check($sformatf("v%0d start_to_load", n), 32'({o_busy, o_ready}), 32'h3);
        check($sformatf("v%0d done_cleared", n), 32'(o_done), 32'h0);
        stall = (v.stall_max > 0) ? int'($urandom_range(v.stall_max, 0)) : 0;
        for (int c = 0; c < 300 && !seen_done; c++) begin
            if (o_done) begin
                seen_done = 1'b1;
            end else begin
                ncyc++;
                if (o_shift) begin
                    cap = {cap[14:0], o_head};
                    nshift++;
                    err_last = o_err;
                    word_valid = v.poke;
                    word_in = 8'h00;
                    start_a = v.poke && !v.sel_b;
                    start_b = v.poke && v.sel_b;
                end else begin
                    start_a = 1'b0;
                    start_b = 1'b0;
                    if (o_ready && stall > 0) begin
                        word_valid = 1'b0;
                        stall--;
                    end else if (o_ready) begin
                        word_valid = 1'b1;
                        word_in = (widx < 2) ? words[widx] : 8'h00;
                        widx++;
                        stall = (v.stall_max > 0) ? int'($urandom_range(v.stall_max, 0)) : 0;
                    end else begin
                        word_valid = 1'b0;
                    end
                end
                @(negedge clk);
            end
        end
        word_valid = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        check($sformatf("v%0d done_seen", n), 32'(seen_done), 32'h1);
        check($sformatf("v%0d busy_at_done", n), 32'(o_busy), 32'h0);
        check($sformatf("v%0d shift_count", n), 32'(nshift), 32'(v.exp_len));
        check($sformatf("v%0d head_bits", n), 32'(cap), 32'(v.exp_bits));
        check($sformatf("v%0d words_taken", n), 32'(widx), 32'h2);
        check($sformatf("v%0d err_before_last", n), 32'(err_last), 32'(v.exp_pre));
        check($sformatf("v%0d err_final", n), 32'(o_err), 32'(v.exp_err));
        if (v.stall_max == 0)
            check($sformatf("v%0d pass_cycles", n), 32'(ncyc), 32'(v.exp_len + (v.exp_len + 7) / 8));
        if (!v.sel_b && !v.vfy)
            check($sformatf("v%0d chain_contents", n), 32'(chain16), 32'(v.exp_bits));
        @(negedge clk);
        check($sformatf("v%0d done_held", n), 32'({o_done, o_busy, o_shift}), 32'h4);
    endtask

    initial begin
        //           sel_b  vfy   w0     w1     exp_bits  len pre   err   stall poke
        vecs[0] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 16'hA53C, 16, 1'b0, 1'b0, 0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 16'hA53C, 16, 1'b0, 1'b0, 0, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 8'hA5, 8'h3D, 16'hA53D, 16, 1'b0, 1'b1, 0, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 8'hA5, 8'h3C, 16'hA53C, 16, 1'b0, 1'b0, 5, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 16'hA53C, 16, 1'b0, 1'b0, 5, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h9F, 16'h0FF9, 12, 1'b0, 1'b0, 0, 1'b0};
        vecs[6] = '{1'b0, 1'b0, 8'h3C, 8'hA5, 16'h3CA5, 16, 1'b0, 1'b0, 0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 16'h3CA5, 16, 1'b0, 1'b0, 3, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 16'hA53C, 16, 1'b1, 1'b1, 0, 1'b0};

        #12;
        check("reset_outputs_a", 32'({ready_a, head_a, shift_a, busy_a, done_a, err_a}), 32'h0);
        check("reset_outputs_b", 32'({ready_b, head_b, shift_b, busy_b, done_b, err_b}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-SHIFT aborts asynchronously
        sel_b = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        verify = 1'b0;
        @(negedge clk);
        start_a = 1'b0;
        check("first_load_ready", 32'({busy_a, ready_a, shift_a}), 32'h6);
        word_valid = 1'b1;
        word_in = 8'hA5;
        @(negedge clk);
        word_valid = 1'b0;
        check("first_bit_latency", 32'({shift_a, head_a, ready_a}), 32'h6);
        @(negedge clk);
        check("second_bit", 32'({shift_a, head_a}), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_shift", 32'({ready_a, head_a, shift_a, busy_a, done_a, err_a}), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        word_valid = 1'b1;
        word_in = 8'h55;
        @(negedge clk);
        @(negedge clk);
        check("valid_in_idle_ignored", 32'({ready_a, shift_a, busy_a}), 32'h0);
        word_valid = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_pass(i, vecs[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
